sequential_bit_wise_shift_left: RTL and testbench

//  - Multi-cycle logical shift-left engine. Companion to the structural right shifter.
//  - Applies one binary-weighted stage per clock: shift by 2**k when b[k]=1. Zeros fill from the LSB.
//  - Handshaked operand in (valid/ready) and result out (valid/ready), with a sticky overflow flag.
//  - Sits in the BitWise unit as the area-lean alternative to the combinational shifters.

---
 rtl/bit_wise_pkg.sv | 18 +
 rtl/bit_wise_shift_left_stage.sv | 32 +++
 rtl/sequential_bit_wise_shift_left.sv | 122 ++++++++++++
 tb/tb_sequential_bit_wise_shift_left.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bit_wise_pkg.sv
// Shared definitions for the BitWise shift engines.
//  - shift_state_e : FSM encoding of the multi-cycle shifters (IDLE, SHIFT, DONE)
//  - stage_width() : width in bits of binary-weighted stage k, i.e. 2**k
package bit_wise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  localparam int unsigned STAGE_BASE = 1;

  function automatic int unsigned stage_width(input int unsigned k);
    return STAGE_BASE << k;
  endfunction

endpackage

// File: rtl/bit_wise_shift_left_stage.sv
// One binary-weighted logical shift-left stage, reused every cycle by the
// sequential shifter.
//  i_acc  : current accumulator
//  i_k    : stage index; the stage shifts by 2**i_k
//  i_en   : 1 = apply the stage, 0 = pass i_acc through untouched
//  o_acc  : shifted (or passed-through) accumulator, zeros fill from the LSB
//  o_lost : 1 if any '1' bit was pushed out past bit N-1 by this stage
module bit_wise_shift_left_stage #(
  parameter int N = 8,
  parameter int O = $clog2(N)
) (
  input  logic [N-1:0] i_acc,
  input  logic [O-1:0] i_k,
  input  logic         i_en,
  output logic [N-1:0] o_acc,
  output logic         o_lost
);
  import bit_wise_pkg::*;

  logic [31:0]  w_width;
  logic [N-1:0] w_shifted;
  logic [N-1:0] w_top_mask;

  assign w_width   = stage_width(32'(i_k));
  // A stage of width >= N shifts everything out: result 0, mask covers all bits.
  assign w_shifted  = i_acc << w_width;
  assign w_top_mask = ~({N{1'b1}} >> w_width);

  assign o_acc  = i_en ? w_shifted : i_acc;
  assign o_lost = i_en & (|(i_acc & w_top_mask));

endmodule

// File: rtl/sequential_bit_wise_shift_left.sv
// Multi-cycle logical shift-left engine: one binary-weighted stage per clock,
// handshaked operand in and result out, sticky overflow flag.
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  in_valid   : operand a/b present
//  in_ready   : engine idle, accepts a/b this cycle
//  a, b       : operand and shift amount
//  out_valid  : c/ovf valid
//  out_ready  : consumer takes c/ovf
//  c          : a << b truncated to N bits (driven from the accumulator always)
//  ovf        : 1 if any '1' bit of a was shifted out past bit N-1
module sequential_bit_wise_shift_left #(
  parameter int N          = 8,
  parameter int O          = $clog2(N),
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [O-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);
  import bit_wise_pkg::*;

  localparam logic [O-1:0] K_LAST = O'(O - 1);

  shift_state_e r_state;
  shift_state_e w_state_next;

  logic [N-1:0] r_acc;
  logic [O-1:0] r_amt;
  logic [O-1:0] r_k;
  logic         r_ovf;

  logic [N-1:0] w_stage_acc;
  logic         w_stage_lost;
  logic         w_stage_en;
  logic [O-1:0] w_amt_rest;
  logic         w_last_stage;
  logic         w_accept;
  logic         w_release;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign c         = r_acc;
  assign ovf       = r_ovf;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // Mask-based select keeps the bit pick width-clean for any O.
  assign w_stage_en = |(r_amt & (O'(1) << r_k));

  // Shift-amount bits above the current stage; zero means nothing left to do.
  assign w_amt_rest   = r_amt >> (32'(r_k) + 32'd1);
  assign w_last_stage = (r_k == K_LAST) || (EARLY_EXIT && (w_amt_rest == '0));

  bit_wise_shift_left_stage #(
    .N (N),
    .O (O)
  ) u_stage (
    .i_acc  (r_acc),
    .i_k    (r_k),
    .i_en   (w_stage_en),
    .o_acc  (w_stage_acc),
    .o_lost (w_stage_lost)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)     w_state_next = SHIFT;
      SHIFT:   if (w_last_stage) w_state_next = DONE;
      DONE:    if (w_release)    w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_amt <= '0;
      r_k   <= '0;
      r_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= a;
            r_amt <= b;
            r_k   <= '0;
            r_ovf <= 1'b0;
          end
        end
        SHIFT: begin
          r_acc <= w_stage_acc;
          r_ovf <= r_ovf | w_stage_lost;
          if (!w_last_stage) r_k <= r_k + O'(1);
        end
        default: begin
          // DONE holds c/ovf stable under backpressure.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_bit_wise_shift_left.sv
module tb_sequential_bit_wise_shift_left;

  logic       clk;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] a         [2];
  logic [2:0] b         [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] c         [2];
  logic       ovf       [2];

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: full-latency engine; instance 1: early exit.
  sequential_bit_wise_shift_left #(.N(8), .O(3), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .c(c[0]), .ovf(ovf[0])
  );

  sequential_bit_wise_shift_left #(.N(8), .O(3), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .c(c[1]), .ovf(ovf[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Accept one operand, measure accept-to-out_valid edges, check result, drain.
  task automatic do_op(input int sel, input string tag, input logic [7:0] ta,
                       input logic [2:0] tb_b, input logic [7:0] ec, input logic eo,
                       input int elat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready[sel]), 32'd1);
    a[sel] = ta;
    b[sel] = tb_b;
    in_valid[sel] = 1'b1;
    @(posedge clk);
    #1 in_valid[sel] = 1'b0;
    lat = 0;
    while (!out_valid[sel] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_c"}, 32'(c[sel]), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf[sel]), 32'(eo));
    @(negedge clk);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1 out_ready[sel] = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid[sel]), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready[sel]), 32'd1);
  endtask

  initial begin
    logic [15:0] wide;
    logic [7:0]  sweep_a [2];
    int          lat_ee;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a[i]         = '0;
      b[i]         = '0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_c", i), 32'(c[i]), 32'd0);
      check($sformatf("rst%0d_ovf", i), 32'(ovf[i]), 32'd0);
      check($sformatf("rst%0d_out_valid", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("rst%0d_in_ready", i), 32'(in_ready[i]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, full-latency engine.
    do_op(0, "a01_b3",   8'h01, 3'd3, 8'h08, 1'b0, 3);
    do_op(0, "aF0_b1",   8'hF0, 3'd1, 8'hE0, 1'b1, 3);
    do_op(0, "aFF_b7",   8'hFF, 3'd7, 8'h80, 1'b1, 3);
    do_op(0, "a5A_b0",   8'h5A, 3'd0, 8'h5A, 1'b0, 3);
    do_op(0, "a0F_b4",   8'h0F, 3'd4, 8'hF0, 1'b0, 3);
    do_op(0, "a1F_b4",   8'h1F, 3'd4, 8'hF0, 1'b1, 3);
    do_op(0, "a40_b3",   8'h40, 3'd3, 8'h00, 1'b1, 3);

    // Directed vectors, early-exit engine.
    do_op(1, "ee_a5A_b0", 8'h5A, 3'd0, 8'h5A, 1'b0, 1);
    do_op(1, "ee_a03_b2", 8'h03, 3'd2, 8'h0C, 1'b0, 2);
    do_op(1, "ee_a81_b1", 8'h81, 3'd1, 8'h02, 1'b1, 1);
    do_op(1, "ee_aFF_b7", 8'hFF, 3'd7, 8'h80, 1'b1, 3);

    // Backpressure: result held 5 cycles, new operand ignored until drained.
    @(negedge clk);
    a[0] = 8'h21;
    b[0] = 3'd2;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a[0] = 8'h03;
    b[0] = 3'd1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_out_valid", i), 32'(out_valid[0]), 32'd1);
      check($sformatf("bp%0d_c", i), 32'(c[0]), 32'h84);
      check($sformatf("bp%0d_ovf", i), 32'(ovf[0]), 32'd0);
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready[0]), 32'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    check("bp_release_valid", 32'(out_valid[0]), 32'd0);
    check("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    check("bp_reaccept_in_ready", 32'(in_ready[0]), 32'd0);
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp_next_latency", 32'(lat), 32'd3);
    check("bp_next_c", 32'(c[0]), 32'h06);
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;

    // Asynchronous reset mid-SHIFT.
    @(negedge clk);
    a[0] = 8'hFF;
    b[0] = 3'd7;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_c_before_rst", 32'(c[0]), 32'hFE);
    check("mid_ovf_before_rst", 32'(ovf[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_c", 32'(c[0]), 32'd0);
    check("mid_rst_ovf", 32'(ovf[0]), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("mid_rst_no_valid", 32'(out_valid[0]), 32'd0);
    do_op(0, "post_rst_a03_b2", 8'h03, 3'd2, 8'h0C, 1'b0, 3);

    // Shift-amount sweep on both engines; expected values come from a 16-bit widened shift.
    sweep_a[0] = 8'h96;
    sweep_a[1] = 8'h01;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 8; s++) begin
        wide = {8'h00, sweep_a[p]} << s;
        lat_ee = (s == 0) ? 1 : (s < 2) ? 1 : (s < 4) ? 2 : 3;
        do_op(0, $sformatf("sw_a%0h_b%0d", sweep_a[p], s), sweep_a[p], 3'(s),
              wide[7:0], |wide[15:8], 3);
        do_op(1, $sformatf("sw_ee_a%0h_b%0d", sweep_a[p], s), sweep_a[p], 3'(s),
              wide[7:0], |wide[15:8], lat_ee);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
